// File: rtl/elevator_call_dispatcher_if.sv
// Call-dispatcher bundle: button inputs, car status, FSM request and lamp outputs.
interface elevator_call_dispatcher_if #(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_W    = 3
);
    logic [NUM_FLOORS-1:0] hall_up_btn;
    logic [NUM_FLOORS-1:0] hall_dn_btn;
    logic [NUM_FLOORS-1:0] car_btn;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  door;
    logic                  emergency_stop;
    logic [FLOOR_W-1:0]    req_floor;
    logic                  req_valid;
    logic [NUM_FLOORS-1:0] hall_up_lamp;
    logic [NUM_FLOORS-1:0] hall_dn_lamp;
    logic [NUM_FLOORS-1:0] car_lamp;
    logic                  busy;

    modport master (
        output hall_up_btn, hall_dn_btn, car_btn, current_floor, door, emergency_stop,
        input  req_floor, req_valid, hall_up_lamp, hall_dn_lamp, car_lamp, busy
    );

    modport slave (
        input  hall_up_btn, hall_dn_btn, car_btn, current_floor, door, emergency_stop,
        output req_floor, req_valid, hall_up_lamp, hall_dn_lamp, car_lamp, busy
    );
endinterface

// File: rtl/elevator_call_dispatcher.sv
// Latches hall/car calls, serialises unissued floors round-robin to the elevator FSM.
// Optional macro ELEVATOR_CAR_PRIORITY_EN: car calls are issued ahead of hall calls.
module elevator_call_dispatcher #(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_W    = 3
) (
    input logic                        clk,
    input logic                        reset,
    elevator_call_dispatcher_if.slave  io_bus
);

    localparam int unsigned CNT_W = FLOOR_W + 1;

    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_ISSUE  = 2'd1,
        D_FREEZE = 2'd2
    } state_t;

    state_t                r_state;
    logic [NUM_FLOORS-1:0] r_hup;
    logic [NUM_FLOORS-1:0] r_hdn;
    logic [NUM_FLOORS-1:0] r_car;
    logic [NUM_FLOORS-1:0] r_issued;
    logic [FLOOR_W-1:0]    r_rr_ptr;
    logic [FLOOR_W-1:0]    r_req_floor;
    logic                  r_req_valid;
    logic                  r_busy;

    logic [NUM_FLOORS-1:0] w_svc;
    logic [NUM_FLOORS-1:0] w_hup_n;
    logic [NUM_FLOORS-1:0] w_hdn_n;
    logic [NUM_FLOORS-1:0] w_car_n;
    logic [NUM_FLOORS-1:0] w_issued_clr;
    logic [NUM_FLOORS-1:0] w_car_un;
    logic [NUM_FLOORS-1:0] w_hall_un;
    logic [NUM_FLOORS-1:0] w_pick_mask;
    logic [FLOOR_W:0]      w_pick;
    logic [FLOOR_W-1:0]    w_sel;
    logic                  w_issue;
    logic [NUM_FLOORS-1:0] w_sel_oh;
    logic [NUM_FLOORS-1:0] w_issued_n;
    logic [NUM_FLOORS-1:0] w_call_n;
    logic [NUM_FLOORS-1:0] w_unissued_n;
    logic [NUM_FLOORS-1:0] w_unissued_q;
    logic [CNT_W-1:0]      w_ptr_inc;
    logic [FLOOR_W-1:0]    w_ptr_n;

    // First set bit of mask at or after ptr, wrapping; MSB of result flags a hit.
    function automatic logic [FLOOR_W:0] rr_pick(input logic [NUM_FLOORS-1:0] mask,
                                                 input logic [FLOOR_W-1:0]    ptr);
        logic [FLOOR_W:0] res;
        int unsigned      idx;
        res = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_FLOORS) idx = idx - NUM_FLOORS;
            if (!res[FLOOR_W] && mask[FLOOR_W'(idx)]) res = {1'b1, FLOOR_W'(idx)};
        end
        return res;
    endfunction

    // Door-open service clear; suppressed while frozen since the door reads open then.
    always_comb begin
        w_svc = '0;
        if (io_bus.door && !io_bus.emergency_stop && (r_state != D_FREEZE) &&
            ({1'b0, io_bus.current_floor} < CNT_W'(NUM_FLOORS)))
            w_svc[io_bus.current_floor] = 1'b1;
    end

    assign w_hup_n      = (r_hup | io_bus.hall_up_btn) & ~w_svc;
    assign w_hdn_n      = (r_hdn | io_bus.hall_dn_btn) & ~w_svc;
    assign w_car_n      = (r_car | io_bus.car_btn)     & ~w_svc;
    assign w_issued_clr = r_issued & ~w_svc;
    assign w_car_un     = r_car & ~w_svc & ~w_issued_clr;
    assign w_hall_un    = (r_hup | r_hdn) & ~w_svc & ~w_issued_clr;
    assign w_unissued_q = (r_hup | r_hdn | r_car) & ~r_issued;

`ifdef ELEVATOR_CAR_PRIORITY_EN
    assign w_pick_mask = (w_car_un != '0) ? w_car_un : w_hall_un;
`else
    assign w_pick_mask = w_car_un | w_hall_un;
`endif

    assign w_pick    = rr_pick(w_pick_mask, r_rr_ptr);
    assign w_sel     = w_pick[FLOOR_W-1:0];
    assign w_issue   = (r_state == D_ISSUE) && !io_bus.emergency_stop && w_pick[FLOOR_W];
    assign w_sel_oh  = w_issue ? (NUM_FLOORS'(1) << w_sel) : '0;
    assign w_ptr_inc = {1'b0, w_sel} + CNT_W'(1);
    assign w_ptr_n   = (w_ptr_inc == CNT_W'(NUM_FLOORS)) ? '0 : FLOOR_W'(w_ptr_inc);

    // Leaving freeze drops the issued mask so every pending call is offered again.
    always_comb begin
        w_issued_n = w_issued_clr | w_sel_oh;
        if (r_state == D_FREEZE)
            w_issued_n = io_bus.emergency_stop ? r_issued : '0;
    end

    assign w_call_n     = w_hup_n | w_hdn_n | w_car_n;
    assign w_unissued_n = w_call_n & ~w_issued_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= D_IDLE;
            r_hup       <= '0;
            r_hdn       <= '0;
            r_car       <= '0;
            r_issued    <= '0;
            r_rr_ptr    <= '0;
            r_req_floor <= '0;
            r_req_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_hup       <= w_hup_n;
            r_hdn       <= w_hdn_n;
            r_car       <= w_car_n;
            r_issued    <= w_issued_n;
            r_busy      <= |w_call_n;
            r_req_valid <= w_issue;
            if (w_issue) begin
                r_req_floor <= w_sel;
                r_rr_ptr    <= w_ptr_n;
            end
            case (r_state)
                D_IDLE: begin
                    if (io_bus.emergency_stop)   r_state <= D_FREEZE;
                    else if (w_unissued_q != '0) r_state <= D_ISSUE;
                end
                D_ISSUE: begin
                    if (io_bus.emergency_stop)   r_state <= D_FREEZE;
                    else if (w_unissued_n == '0) r_state <= D_IDLE;
                end
                D_FREEZE: begin
                    if (!io_bus.emergency_stop)  r_state <= D_IDLE;
                end
                default: r_state <= D_IDLE;
            endcase
        end
    end

    assign io_bus.req_floor    = r_req_floor;
    assign io_bus.req_valid    = r_req_valid;
    assign io_bus.hall_up_lamp = r_hup;
    assign io_bus.hall_dn_lamp = r_hdn;
    assign io_bus.car_lamp     = r_car;
    assign io_bus.busy         = r_busy;

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Directed scenarios plus randomized traffic against a floor-level reference model.
module tb_elevator_call_dispatcher;

    localparam int unsigned N  = 8;
    localparam int unsigned FW = 3;
    localparam int M_IDLE   = 0;
    localparam int M_ISSUE  = 1;
    localparam int M_FREEZE = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    elevator_call_dispatcher_if #(.NUM_FLOORS(N), .FLOOR_W(FW)) bus ();

    elevator_call_dispatcher #(.NUM_FLOORS(N), .FLOOR_W(FW)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0] m_hup, m_hdn, m_car, m_iss;
    int           m_ptr, m_mode, m_rf;
    logic         m_rv, m_busy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] cand, input int ptr);
        for (int k = 0; k < int'(N); k++) begin
            int f;
            f = (ptr + k) % int'(N);
            if (cand[f]) return f;
        end
        return -1;
    endfunction

    // Reference: one clock edge of dispatcher behaviour from the current inputs.
    task automatic model_edge();
        logic [N-1:0] keep, car_c, hall_c;
        int           sel;
        bit           issue, any_pre;
        if (reset) begin
            m_hup = '0; m_hdn = '0; m_car = '0; m_iss = '0;
            m_ptr = 0; m_mode = M_IDLE; m_rf = 0; m_rv = 1'b0; m_busy = 1'b0;
            return;
        end
        keep = '1;
        if (bus.door && !bus.emergency_stop && m_mode != M_FREEZE && int'(bus.current_floor) < int'(N))
            keep = ~(N'(1) << bus.current_floor);
        any_pre = ((m_hup | m_hdn | m_car) & ~m_iss) != '0;
        car_c   = m_car & keep & ~m_iss;
        hall_c  = (m_hup | m_hdn) & keep & ~m_iss;
`ifdef ELEVATOR_CAR_PRIORITY_EN
        sel = pick(car_c, m_ptr);
        if (sel < 0) sel = pick(hall_c, m_ptr);
`else
        sel = pick(car_c | hall_c, m_ptr);
`endif
        issue = (m_mode == M_ISSUE) && !bus.emergency_stop && (sel >= 0);
        m_hup = (m_hup | bus.hall_up_btn) & keep;
        m_hdn = (m_hdn | bus.hall_dn_btn) & keep;
        m_car = (m_car | bus.car_btn) & keep;
        m_iss = m_iss & keep;
        if (issue) begin
            m_iss = m_iss | (N'(1) << sel);
            m_rf  = sel;
            m_ptr = (sel + 1) % int'(N);
        end
        m_rv = issue;
        if (m_mode == M_FREEZE && !bus.emergency_stop) m_iss = '0;
        m_busy = (m_hup | m_hdn | m_car) != '0;
        case (m_mode)
            M_IDLE:  m_mode = bus.emergency_stop ? M_FREEZE : (any_pre ? M_ISSUE : M_IDLE);
            M_ISSUE: m_mode = bus.emergency_stop ? M_FREEZE :
                              (((m_hup | m_hdn | m_car) & ~m_iss) != '0 ? M_ISSUE : M_IDLE);
            default: m_mode = bus.emergency_stop ? M_FREEZE : M_IDLE;
        endcase
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_eq("hup_lamp",  32'(bus.hall_up_lamp), 32'(m_hup));
        check_eq("hdn_lamp",  32'(bus.hall_dn_lamp), 32'(m_hdn));
        check_eq("car_lamp",  32'(bus.car_lamp),     32'(m_car));
        check_eq("busy",      32'(bus.busy),         32'(m_busy));
        check_eq("req_valid", 32'(bus.req_valid),    32'(m_rv));
        check_eq("req_floor", 32'(bus.req_floor),    32'(m_rf));
    endtask

    task automatic idle_inputs();
        bus.hall_up_btn = '0; bus.hall_dn_btn = '0; bus.car_btn = '0;
        bus.current_floor = '0; bus.door = 1'b0; bus.emergency_stop = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int estop_cnt;

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst_lamps", 32'(bus.hall_up_lamp | bus.hall_dn_lamp | bus.car_lamp), 32'h0);
        check_eq("rst_valid", 32'(bus.req_valid), 32'h0);
        check_eq("rst_busy",  32'(bus.busy), 32'h0);
        reset = 1'b0;

        // Single hall-up call at floor 5
        bus.hall_up_btn = 8'h20;
        tick();
        bus.hall_up_btn = '0;
        check_eq("single_lamp", 32'(bus.hall_up_lamp), 32'h20);
        check_eq("single_busy", 32'(bus.busy), 32'h1);
        check_eq("single_v0",   32'(bus.req_valid), 32'h0);
        tick();
        check_eq("single_v1",   32'(bus.req_valid), 32'h0);
        tick();
        check_eq("single_v2",   32'(bus.req_valid), 32'h1);
        check_eq("single_fl",   32'(bus.req_floor), 32'd5);
        tick();
        check_eq("single_v3",   32'(bus.req_valid), 32'h0);

        // Round-robin over car calls 1, 4, 7
        do_reset();
        bus.car_btn = 8'b1001_0010;
        tick();
        bus.car_btn = '0;
        tick();
        tick();
        check_eq("rr_fl0", 32'(bus.req_floor), 32'd1);
        tick();
        check_eq("rr_fl1", 32'(bus.req_floor), 32'd4);
        tick();
        check_eq("rr_fl2", 32'(bus.req_floor), 32'd7);
        check_eq("rr_v2",  32'(bus.req_valid), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rr_quiet", 32'(bus.req_valid), 32'h0);
        end

        // Service clear at floor 3 beats a simultaneous car press
        do_reset();
        bus.hall_up_btn = 8'h08; bus.hall_dn_btn = 8'h08; bus.car_btn = 8'h08;
        tick();
        idle_inputs();
        tick();
        tick();
        check_eq("svc_issue", 32'(bus.req_floor), 32'd3);
        bus.current_floor = 3'd3; bus.door = 1'b1; bus.car_btn = 8'h08;
        tick();
        idle_inputs();
        check_eq("svc_lamps", 32'(bus.hall_up_lamp | bus.hall_dn_lamp | bus.car_lamp), 32'h0);
        check_eq("svc_busy",  32'(bus.busy), 32'h0);
        tick();

        // Emergency freeze with door open at floor 2, then re-issue
        do_reset();
        bus.car_btn = 8'h44;
        tick();
        bus.car_btn = '0;
        tick();
        tick();
        tick();
        check_eq("em_pre_fl", 32'(bus.req_floor), 32'd6);
        bus.emergency_stop = 1'b1; bus.door = 1'b1; bus.current_floor = 3'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("em_valid", 32'(bus.req_valid), 32'h0);
            check_eq("em_lamp",  32'(bus.car_lamp), 32'h44);
        end
        idle_inputs();
        tick();
        tick();
        tick();
        check_eq("em_re0", 32'(bus.req_floor), 32'd2);
        check_eq("em_rv0", 32'(bus.req_valid), 32'h1);
        tick();
        check_eq("em_re1", 32'(bus.req_floor), 32'd6);
        tick();

        // Reset while issuing with three unissued floors
        do_reset();
        bus.car_btn = 8'h23;
        tick();
        bus.car_btn = '0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_v",    32'(bus.req_valid), 32'h0);
        check_eq("mid_rst_lmp",  32'(bus.hall_up_lamp | bus.hall_dn_lamp | bus.car_lamp), 32'h0);
        check_eq("mid_rst_busy", 32'(bus.busy), 32'h0);
        tick();
        check_eq("mid_rst_idle", 32'(bus.req_valid), 32'h0);

`ifdef ELEVATOR_CAR_PRIORITY_EN
        // Car call at 6 wins over hall-down at 1
        do_reset();
        bus.hall_dn_btn = 8'h02; bus.car_btn = 8'h40;
        tick();
        idle_inputs();
        tick();
        tick();
        check_eq("prio_first",  32'(bus.req_floor), 32'd6);
        tick();
        check_eq("prio_second", 32'(bus.req_floor), 32'd1);
`endif

        // Randomized traffic
        do_reset();
        estop_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] hu, hd, cb;
            for (int b = 0; b < int'(N); b++) begin
                hu[b] = ($urandom_range(0, 15) == 0);
                hd[b] = ($urandom_range(0, 15) == 0);
                cb[b] = ($urandom_range(0, 11) == 0);
            end
            if (estop_cnt > 0) estop_cnt--;
            else if ($urandom_range(0, 59) == 0) estop_cnt = int'($urandom_range(1, 8));
            bus.hall_up_btn    = hu;
            bus.hall_dn_btn    = hd;
            bus.car_btn        = cb;
            bus.current_floor  = FW'($urandom_range(0, N - 1));
            bus.door           = ($urandom_range(0, 3) == 0);
            bus.emergency_stop = (estop_cnt > 0);
            reset              = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_call_dispatcher.md
Name: elevator_call_dispatcher

Overview:
- Front-end scheduler for the elevator FSM.
- Collects hall-up, hall-down and car-panel button presses into per-floor pending registers and drives lamps.
- Serialises unissued calls onto the FSM's req_floor/req_valid interface, one floor per cycle, in round-robin order.
- Clears calls when the car services a floor (door open at that floor), and freezes dispatch during emergency stop.

Parameters:
- NUM_FLOORS, 8, number of floors; one bit per floor in every mask.
- FLOOR_W, 3, width of floor indices; NUM_FLOORS <= 2**FLOOR_W.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the clk rising edge.
- hall_up_btn  in  NUM_FLOORS  hall up-call buttons, one bit per floor; level sampled every cycle.
- hall_dn_btn  in  NUM_FLOORS  hall down-call buttons, one bit per floor.
- car_btn  in  NUM_FLOORS  car-panel floor buttons, one bit per floor.
- current_floor  in  FLOOR_W  car position from the elevator FSM.
- door  in  1  FSM door status; 1 = open.
- emergency_stop  in  1  emergency stop input, shared with the FSM.
- req_floor  out  FLOOR_W  registered floor index presented to the FSM.
- req_valid  out  1  registered; 1-cycle pulse per issued call.
- hall_up_lamp  out  NUM_FLOORS  pending hall-up calls.
- hall_dn_lamp  out  NUM_FLOORS  pending hall-down calls.
- car_lamp  out  NUM_FLOORS  pending car calls.
- busy  out  1  1 when any call is pending (issued or not).

Behaviour:
- Reset: all lamps, the issued mask, req_floor, req_valid, busy and rr_ptr are 0; state = D_IDLE. Reset mid-operation discards all calls; there is no partial state.
- Pending registers: hup, hdn, car, each NUM_FLOORS wide.
  - A button bit high at an edge sets the matching register bit.
  - Holding a button does not re-trigger once the bit is set.
- call_mask = hup | hdn | car.
- issued mask: bit f is set when floor f is emitted on req_floor.
- Service clear: at an edge with door=1, emergency_stop=0 and current_floor=f, the block clears hup[f], hdn[f], car[f] and issued[f].
  - Service beats a simultaneous button press at floor f; the bit stays 0.
- Unissued set: unissued = call_mask & ~issued.
- Arbitration: round-robin over unissued.
  - Selects the first set bit at index >= rr_ptr, wrapping past NUM_FLOORS-1 to 0.
  - On issue, rr_ptr = (selected floor + 1) mod NUM_FLOORS.
- States:
  - D_IDLE: req_valid=0. If emergency_stop=1, go to D_FREEZE. Else if unissued != 0, go to D_ISSUE.
  - D_ISSUE: each edge, if emergency_stop=0 and unissued != 0 (after the same-edge service clear is applied), the block registers req_floor = selected floor and req_valid = 1, then sets issued[sel]. Otherwise req_valid = 0. Transitions:
    - emergency_stop=1: go to D_FREEZE.
    - unissued becomes 0: go to D_IDLE.
    - otherwise stay in D_ISSUE.
  - D_FREEZE: req_valid=0; req_floor holds its value.
    - Button latching continues. Service clears are suppressed, because the door reads open during an emergency.
    - When emergency_stop falls, the issued mask is cleared to 0 so every pending call is re-issued; go to D_IDLE.
- Latency: a press captured at edge k, with no competing unissued floor, gives req_valid=1 with req_floor=f after edge k+2 (one edge D_IDLE to D_ISSUE, one edge to the registered output).
- Throughput: one issue per cycle while in D_ISSUE.
- req_valid never stays high two cycles for the same floor unless that floor was serviced and then re-pressed in between.
- busy = |call_mask, registered together with the masks.
- Lamps are direct copies of hup, hdn, car.

Optional Feature:
- Macro: ELEVATOR_CAR_PRIORITY_EN.
- Defined: arbitration first round-robins over car & ~issued. Hall calls ((hup|hdn) & ~issued) are issued only when no car call is unissued. A single shared rr_ptr is used for both.
- Undefined: a single round-robin runs over the merged unissued mask, as described in Behaviour.

Test Plan:
- Single call: reset, then hall_up_btn[5]=1 for 1 cycle with current_floor=0 -> hall_up_lamp=8'h20 next cycle; one req_valid pulse with req_floor=5, 2 edges after the press; busy=1.
- Round-robin: car_btn=8'b1001_0010 in one cycle, rr_ptr=0 -> req_floor sequence 1, 4, 7 on consecutive cycles; rr_ptr ends at 0; no further pulses.
- Service clear: floor 3 pending and issued; drive current_floor=3, door=1 -> all lamps at bit 3 clear next edge; a simultaneous car_btn[3] press is ignored.
- Emergency: floors 2 and 6 issued; emergency_stop=1 for 5 cycles with door=1 at floor 2 -> no clears, req_valid=0 throughout. On release, 2 and 6 are re-issued in round-robin order.
- Reset mid-issue: assert reset while in D_ISSUE with 3 floors unissued -> req_valid=0 after the edge, all masks and lamps 0, state D_IDLE.
- With ELEVATOR_CAR_PRIORITY_EN: hall_dn_btn[1] and car_btn[6] pressed together -> req_floor=6 issued before 1.
